// File: rtl/fir_pkg.sv
// Shared definitions for the fir_seq_mac slice: register map, ap_ctrl bit
// positions, FSM state encoding and accumulator sizing.
// Build option: FIR_SAT_EN selects saturating output (ap_ctrl bit4 reports it).
package fir_pkg;

  localparam logic [31:0] ADDR_AP_CTRL  = 32'h00;
  localparam logic [31:0] ADDR_DATA_LEN = 32'h10;
  localparam logic [31:0] ADDR_TAP_NUM  = 32'h14;
  localparam logic [31:0] ADDR_TAP_BASE = 32'h20;

  localparam int unsigned CTRL_START     = 0;
  localparam int unsigned CTRL_DONE      = 1;
  localparam int unsigned CTRL_IDLE      = 2;
  localparam int unsigned CTRL_TLAST_ERR = 3;
  localparam int unsigned CTRL_SAT       = 4;

`ifdef FIR_SAT_EN
  localparam logic SAT_BUILT = 1'b1;
`else
  localparam logic SAT_BUILT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_MAC,
    S_OUT,
    S_DONE
  } fir_state_e;

  // Full product width plus enough guard bits to sum every tap without overflow.
  function automatic int fir_acc_width(input int data_w, input int taps);
    return 2 * data_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared multiply-accumulate for fir_seq_mac: signed full-precision product,
// accumulator with synchronous clear, and output narrowing to the stream width.
// Build option: FIR_SAT_EN saturates the output; otherwise it wraps (truncates).
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = fir_acc_width(32, 16)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_coef,
  input  logic signed [DW-1:0] i_samp,
  output logic        [DW-1:0] o_data
);

  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   r_acc;

  assign w_prod = i_coef * i_samp;

  // Accumulator: clear wins over accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + AW'(w_prod);
    end
  end

`ifdef FIR_SAT_EN
  localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  logic w_fits;
  // The value fits when every bit above the output sign bit copies it.
  assign w_fits = (r_acc[AW-1:DW-1] == '0) || (r_acc[AW-1:DW-1] == '1);

  // Clamp to the signed output range.
  always_comb begin
    o_data = r_acc[DW-1:0];
    if (!w_fits) begin
      o_data = r_acc[AW-1] ? MIN_V : MAX_V;
    end
  end
`else
  logic w_unused_acc_hi;
  assign w_unused_acc_hi = ^r_acc[AW-1:DW];

  // Plain wrap: low bits of the accumulator.
  always_comb begin
    o_data = r_acc[DW-1:0];
  end
`endif

endmodule

// File: rtl/fir_seq_mac.sv
// Sequential FIR engine: AXI-Lite configuration, circular sample store,
// one shared MAC stepping over a runtime tap count, AXI-Stream in/out.
// Build option: FIR_SAT_EN (saturating output, reported in ap_ctrl bit4).
module fir_seq_mac
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int NUM_TAPS    = 16,
  parameter int ACC_WIDTH   = fir_acc_width(pDATA_WIDTH, NUM_TAPS)
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);

  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam int TN_W  = $clog2(NUM_TAPS + 1);

  fir_state_e r_state, w_state_nxt;

  logic                          r_done;
  logic                          r_tlast_err;
  logic [pDATA_WIDTH-1:0]        r_data_len;
  logic [pDATA_WIDTH-1:0]        r_in_cnt;
  logic [TN_W-1:0]               r_tap_num;
  logic [IDX_W-1:0]              r_head;
  logic [IDX_W-1:0]              r_k;
  logic signed [pDATA_WIDTH-1:0] r_tap  [NUM_TAPS];
  logic signed [pDATA_WIDTH-1:0] r_samp [NUM_TAPS];
  logic                          r_rvalid;
  logic [pDATA_WIDTH-1:0]        r_rdata;

  logic                   w_idle;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_start_req;
  logic                   w_rd_ctrl;
  logic [31:0]            w_aw32;
  logic [31:0]            w_ar32;
  logic [TN_W-1:0]        w_tap_num_wr;
  logic [pDATA_WIDTH-1:0] w_rd_mux;
  logic [pDATA_WIDTH-1:0] w_in_cnt_nxt;
  logic [IDX_W-1:0]       w_rd_idx;
  logic                   w_k_last;
  logic                   w_clear_last;
  logic                   w_last_out;
  logic                   w_ss_tready;
  logic                   w_sm_tvalid;
  logic                   w_mac_clr;
  logic                   w_mac_en;
  logic [pDATA_WIDTH-1:0] w_mac_data;

  function automatic logic in_tap_range(input logic [31:0] a);
    return (a >= ADDR_TAP_BASE) && (a < ADDR_TAP_BASE + 32'(4 * NUM_TAPS)) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] tap_index(input logic [31:0] a);
    return IDX_W'((a - ADDR_TAP_BASE) >> 2);
  endfunction

  assign w_idle       = (r_state == S_IDLE);
  assign w_aw32       = 32'(awaddr);
  assign w_ar32       = 32'(araddr);
  assign w_wr         = awvalid && wvalid;
  assign w_rd         = arvalid && !r_rvalid;
  assign w_start_req  = w_wr && (w_aw32 == ADDR_AP_CTRL) && wdata[CTRL_START] && w_idle;
  assign w_rd_ctrl    = w_rd && (w_ar32 == ADDR_AP_CTRL);
  assign w_in_cnt_nxt = r_in_cnt + 1'b1;
  assign w_k_last     = (32'(r_k) == 32'(r_tap_num) - 32'd1);
  assign w_clear_last = (32'(r_k) == 32'(NUM_TAPS - 1));
  assign w_last_out   = (r_in_cnt == r_data_len);

  assign awready   = w_wr;
  assign wready    = w_wr;
  assign arready   = !r_rvalid;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign ss_tready = w_ss_tready;
  assign sm_tvalid = w_sm_tvalid;
  assign sm_tdata  = w_mac_data;
  assign sm_tlast  = w_sm_tvalid && w_last_out;

  // Out-of-range tap counts are clamped into 1..NUM_TAPS.
  always_comb begin
    w_tap_num_wr = TN_W'(wdata);
    if (wdata == '0) begin
      w_tap_num_wr = TN_W'(1);
    end else if (wdata > pDATA_WIDTH'(NUM_TAPS)) begin
      w_tap_num_wr = TN_W'(NUM_TAPS);
    end
  end

  // Sample index for tap k: newest sample minus k, wrapped into the ring.
  always_comb begin
    if (r_head >= r_k) begin
      w_rd_idx = r_head - r_k;
    end else begin
      w_rd_idx = IDX_W'(32'(r_head) + 32'(NUM_TAPS) - 32'(r_k));
    end
  end

  // State register.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state handshake/MAC controls.
  always_comb begin
    w_state_nxt = r_state;
    w_ss_tready = 1'b0;
    w_sm_tvalid = 1'b0;
    w_mac_clr   = 1'b0;
    w_mac_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_req) begin
          w_state_nxt = (r_data_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (w_clear_last) begin
          w_state_nxt = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        w_ss_tready = 1'b1;
        if (ss_tvalid) begin
          w_mac_clr   = 1'b1;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        w_mac_en = 1'b1;
        if (w_k_last) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        w_sm_tvalid = 1'b1;
        if (sm_tready) begin
          w_state_nxt = w_last_out ? S_DONE : S_WAIT_IN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Configuration registers, sample ring, counters and status flags.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_done      <= 1'b0;
      r_tlast_err <= 1'b0;
      r_data_len  <= '0;
      r_in_cnt    <= '0;
      r_tap_num   <= TN_W'(NUM_TAPS);
      r_head      <= '0;
      r_k         <= '0;
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        r_tap[IDX_W'(i)]  <= '0;
        r_samp[IDX_W'(i)] <= '0;
      end
    end else begin
      if (w_wr && w_idle) begin
        if (w_aw32 == ADDR_DATA_LEN) begin
          r_data_len <= wdata;
        end
        if (w_aw32 == ADDR_TAP_NUM) begin
          r_tap_num <= w_tap_num_wr;
        end
        if (in_tap_range(w_aw32)) begin
          r_tap[tap_index(w_aw32)] <= wdata;
        end
      end

      if (w_start_req) begin
        r_tlast_err <= 1'b0;
        r_in_cnt    <= '0;
        r_k         <= '0;
      end

      case (r_state)
        S_CLEAR: begin
          r_samp[r_k] <= '0;
          r_head      <= '0;
          r_k         <= w_clear_last ? '0 : r_k + 1'b1;
        end
        S_WAIT_IN: begin
          if (ss_tvalid) begin
            r_samp[r_head] <= ss_tdata;
            r_in_cnt       <= w_in_cnt_nxt;
            r_k            <= '0;
            if ((ss_tlast && (w_in_cnt_nxt < r_data_len)) ||
                (!ss_tlast && (w_in_cnt_nxt == r_data_len))) begin
              r_tlast_err <= 1'b1;
            end
          end
        end
        S_MAC: begin
          r_k <= w_k_last ? '0 : r_k + 1'b1;
        end
        S_OUT: begin
          if (sm_tready) begin
            r_head <= w_clear_last_head(r_head);
          end
        end
        default: begin
        end
      endcase

      // A done-clearing read coinciding with DONE loses to the set.
      if (r_state == S_DONE) begin
        r_done <= 1'b1;
      end else if (w_rd_ctrl) begin
        r_done <= 1'b0;
      end
    end
  end

  function automatic logic [IDX_W-1:0] w_clear_last_head(input logic [IDX_W-1:0] h);
    return (32'(h) == 32'(NUM_TAPS - 1)) ? '0 : h + 1'b1;
  endfunction

  // Read-data selection; tap contents are hidden while a run is active.
  always_comb begin
    w_rd_mux = '0;
    if (w_ar32 == ADDR_AP_CTRL) begin
      w_rd_mux[CTRL_START]     = !w_idle;
      w_rd_mux[CTRL_DONE]      = r_done;
      w_rd_mux[CTRL_IDLE]      = w_idle;
      w_rd_mux[CTRL_TLAST_ERR] = r_tlast_err;
      w_rd_mux[CTRL_SAT]       = SAT_BUILT;
    end else if (w_ar32 == ADDR_DATA_LEN) begin
      w_rd_mux = r_data_len;
    end else if (w_ar32 == ADDR_TAP_NUM) begin
      w_rd_mux = pDATA_WIDTH'(r_tap_num);
    end else if (in_tap_range(w_ar32)) begin
      w_rd_mux = w_idle ? r_tap[tap_index(w_ar32)] : '1;
    end
  end

  // Read channel: capture on address handshake, hold until rready.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_rd) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_mux;
    end else if (r_rvalid && rready) begin
      r_rvalid <= 1'b0;
    end
  end

  fir_mac_unit #(
    .DW (pDATA_WIDTH),
    .AW (ACC_WIDTH)
  ) u_mac (
    .clk    (axis_clk),
    .rst    (axis_rst),
    .i_clr  (w_mac_clr),
    .i_en   (w_mac_en),
    .i_coef (r_tap[r_k]),
    .i_samp (r_samp[w_rd_idx]),
    .o_data (w_mac_data)
  );

endmodule

// File: tb/tb_fir_seq_mac.sv
// Scoreboard bench for fir_seq_mac: stimulus pushes expected outputs, a
// negedge monitor pops and compares every output-stream handshake.
module tb_fir_seq_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, wvalid, arvalid, rready;
  logic        awready, wready, arready, rvalid;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tvalid, sm_tready, sm_tlast;
  logic [31:0] sm_tdata;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned hs_cyc   = 0;
  int unsigned exp_lat  = 0;
  int unsigned ss_hs    = 0;
  int unsigned sm_hs    = 0;
  logic        prev_valid = 1'b0;

`ifdef FIR_SAT_EN
  localparam logic [31:0] SATB = 32'h10;
`else
  localparam logic [31:0] SATB = 32'h00;
`endif

  fir_seq_mac dut (
    .axis_clk  (clk),
    .axis_rst  (rst),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .ss_tvalid (ss_tvalid),
    .ss_tready (ss_tready),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .sm_tvalid (sm_tvalid),
    .sm_tready (sm_tready),
    .sm_tdata  (sm_tdata),
    .sm_tlast  (sm_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Output monitor: latency on each sm_tvalid rise, data/last on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ss_tvalid && ss_tready) begin
        hs_cyc = cyc;
        ss_hs++;
      end
      if (sm_tvalid && !prev_valid) chk("latency", cyc - hs_cyc, exp_lat);
      prev_valid = sm_tvalid;
      if (sm_tvalid && sm_tready) begin
        sm_hs++;
        if (q.size() == 0) begin
          timeout("unexpected_output");
        end else begin
          e = q.pop_front();
          chk("out_data", sm_tdata, e.data);
          chk("out_last", 32'(sm_tlast), 32'(e.last));
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int unsigned n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin
      timeout("axi_read");
      d = '1;
    end else begin
      d = rdata;
    end
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    chk(name, d, exp);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int unsigned n;
    ss_tdata = d; ss_tlast = last; ss_tvalid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!ss_tready && n < 500) begin @(negedge clk); n++; end
    if (!ss_tready) timeout("ss_handshake");
    @(posedge clk); #1;
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
  endtask

  task automatic expect_out(input logic [31:0] d, input logic last);
    exp_t e;
    e.data = d; e.last = last;
    q.push_back(e);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) timeout("drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cfg_small(input int unsigned len);
    axi_write(12'h20, 32'd1);
    axi_write(12'h24, 32'd2);
    axi_write(12'h28, 32'd3);
    axi_write(12'h14, 32'd3);
    axi_write(12'h10, 32'(len));
    exp_lat = 4;
  endtask

  int h[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  initial begin
    longint      y;
    int unsigned ss0, sm0, n;

    rst = 1'b1; rready = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0;
    ss_tvalid = 1'b0; ss_tlast = 1'b0; ss_tdata = '0; sm_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    chk("rst_ss_tready", 32'(ss_tready), 32'd0);
    rd_chk("rst_ap_ctrl", 12'h00, 32'h4 | SATB);
    rd_chk("rst_tap_num", 12'h14, 32'd16);
    rd_chk("rst_data_len", 12'h10, 32'd0);
    rd_chk("rst_tap0", 12'h20, 32'd0);
    rd_chk("rst_tap15", 12'h5C, 32'd0);
    rd_chk("unmapped_rd", 12'h08, 32'd0);

    // Tap count clamping
    axi_write(12'h14, 32'd0);
    rd_chk("tap_num_zero", 12'h14, 32'd1);
    axi_write(12'h14, 32'd100);
    rd_chk("tap_num_big", 12'h14, 32'd16);

    // 11-tap symmetric filter over a 64-sample ramp
    for (int i = 0; i < 11; i++) axi_write(12'h20 + 12'(4 * i), 32'(h[i]));
    axi_write(12'h14, 32'd11);
    axi_write(12'h10, 32'd64);
    exp_lat = 12;
    axi_write(12'h00, 32'd1);
    for (int nn = 0; nn < 64; nn++) begin
      y = 0;
      for (int k = 0; k < 11; k++) if (nn >= k) y += longint'(h[k]) * longint'(nn - k);
      expect_out(32'(y), nn == 63);
      send(32'(nn), nn == 63);
    end
    drain();
    rd_chk("fir11_ctrl_done", 12'h00, 32'h6 | SATB);
    rd_chk("fir11_ctrl_clr", 12'h00, 32'h4 | SATB);

    // 3 taps, all-ones input
    cfg_small(4);
    axi_write(12'h00, 32'd1);
    expect_out(32'd1, 1'b0); send(32'd1, 1'b0);
    expect_out(32'd3, 1'b0); send(32'd1, 1'b0);
    expect_out(32'd6, 1'b0); send(32'd1, 1'b0);
    expect_out(32'd6, 1'b1); send(32'd1, 1'b1);
    drain();
    rd_chk("tap3_ctrl", 12'h00, 32'h6 | SATB);

    // Output back-pressure with bus accesses during the run
    cfg_small(2);
    axi_write(12'h00, 32'd1);
    sm_tready = 1'b0;
    expect_out(32'd1, 1'b0);
    send(32'd1, 1'b0);
    n = 0;
    while (!sm_tvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!sm_tvalid) timeout("stall_wait_valid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(sm_tvalid), 32'd1);
      chk("stall_data", sm_tdata, 32'd1);
      chk("stall_ss_tready", 32'(ss_tready), 32'd0);
    end
    #1;
    axi_write(12'h20, 32'd99);
    rd_chk("busy_tap_rd", 12'h20, 32'hFFFF_FFFF);
    rd_chk("busy_ctrl", 12'h00, 32'h1 | SATB);
    sm_tready = 1'b1;
    expect_out(32'd3, 1'b1);
    send(32'd1, 1'b1);
    drain();
    rd_chk("stall_ctrl", 12'h00, 32'h6 | SATB);
    rd_chk("busy_wr_ignored", 12'h20, 32'd1);

    // Zero-length run
    ss0 = ss_hs; sm0 = sm_hs;
    axi_write(12'h10, 32'd0);
    axi_write(12'h00, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rd_chk("len0_ctrl", 12'h00, 32'h6 | SATB);
    chk("len0_ss_hs", ss_hs, ss0);
    chk("len0_sm_hs", sm_hs, sm0);

    // Early tlast on sample 2 of 4
    cfg_small(4);
    axi_write(12'h00, 32'd1);
    expect_out(32'd1, 1'b0); send(32'd1, 1'b0);
    expect_out(32'd3, 1'b0); send(32'd1, 1'b1);
    expect_out(32'd6, 1'b0); send(32'd1, 1'b0);
    expect_out(32'd6, 1'b1); send(32'd1, 1'b0);
    drain();
    rd_chk("tlast_err_ctrl", 12'h00, 32'hE | SATB);

    // Full-scale products: saturate or wrap
    axi_write(12'h20, 32'h7FFF_FFFF);
    axi_write(12'h24, 32'h7FFF_FFFF);
    axi_write(12'h14, 32'd2);
    axi_write(12'h10, 32'd2);
    exp_lat = 3;
    axi_write(12'h00, 32'd1);
`ifdef FIR_SAT_EN
    expect_out(32'h7FFF_FFFF, 1'b0);
    send(32'h7FFF_FFFF, 1'b0);
    expect_out(32'h7FFF_FFFF, 1'b1);
    send(32'h7FFF_FFFF, 1'b1);
`else
    expect_out(32'h0000_0001, 1'b0);
    send(32'h7FFF_FFFF, 1'b0);
    expect_out(32'h0000_0002, 1'b1);
    send(32'h7FFF_FFFF, 1'b1);
`endif
    drain();
    rd_chk("sat_ctrl", 12'h00, 32'h6 | SATB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "global timeout");
  end

endmodule
